// File: rtl/usr_seq_ctrl.sv
// rtl/usr_seq_ctrl.sv - command sequencer for a universal shift register
//
// Accepts one LOAD / SHR / SHL / ROT command at a time and drives the mode
// select, serial fill and parallel data of an external universal shift
// register. It then reports completion with a one-cycle done pulse that
// carries the register contents.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid, cmd_ready    command handshake (ready only while idle)
//   cmd_op                  00 LOAD, 01 SHR, 10 SHL, 11 ROT (rotate right)
//   cmd_cnt                 shift steps (ignored for LOAD)
//   cmd_data                parallel value for LOAD
//   cmd_sin                 serial fill bit for SHR / SHL
//   s1, s0                  register mode: 00 hold, 01 right, 10 left, 11 load
//   sr, sl                  serial inputs (sr fills MSB, sl fills LSB)
//   pdin                    parallel data to the register
//   pdout                   current register contents
//   done, err, rsp_data     completion pulse, reject flag, result value
//
// Build option: define USR_SEQ_CTRL_ROT_EN to execute ROT; otherwise ROT is
// rejected (err=1) without touching the register.

module usr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CW-1:0]    cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_sin,
  output logic             s1,
  output logic             s0,
  output logic             sr,
  output logic             sl,
  output logic [WIDTH-1:0] pdin,
  input  logic [WIDTH-1:0] pdout,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rsp_data
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROT  = 2'b11;

`ifdef USR_SEQ_CTRL_ROT_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             sin_q;
  logic             err_q;

  logic accept;
  logic reject;

  assign accept = cmd_valid && (state == ST_IDLE);
  assign reject = (cmd_op == OP_ROT) && !ROT_EN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_LOAD;
      cnt_q  <= '0;
      data_q <= '0;
      sin_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q   <= cmd_op;
        cnt_q  <= cmd_cnt;
        data_q <= cmd_data;
        sin_q  <= cmd_sin;
        err_q  <= reject;
      end else if (state == ST_SHIFT) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    s1        = 1'b0;
    s0        = 1'b0;
    sr        = 1'b0;
    sl        = 1'b0;
    pdin      = '0;
    done      = 1'b0;
    err       = 1'b0;
    rsp_data  = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (reject)                  state_n = ST_DONE;
          else if (cmd_op == OP_LOAD)  state_n = ST_LOAD;
          else if (cmd_cnt == '0)      state_n = ST_DONE;
          else                         state_n = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        s1      = 1'b1;
        s0      = 1'b1;
        pdin    = data_q;
        state_n = ST_DONE;
      end
      ST_SHIFT: begin
        if (op_q == OP_SHL) begin
          s1 = 1'b1;
          sl = sin_q;
        end else begin
          // SHR and ROT both shift right; ROT feeds the outgoing LSB back in.
          s0 = 1'b1;
          sr = (op_q == OP_SHR) ? sin_q : pdout[0];
        end
        // cnt_q holds the steps still to run including this one.
        if (cnt_q == CW'(1)) state_n = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        err      = err_q;
        rsp_data = pdout;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// tb/tb_usr_seq_ctrl.sv - self-checking bench for usr_seq_ctrl

module tb_usr_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       cmd_sin;
  logic       s1, s0, sr, sl;
  logic [3:0] pdin;
  logic [3:0] pdout;
  logic       done, err;
  logic [3:0] rsp_data;

  usr_seq_ctrl #(.WIDTH(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_sin(cmd_sin),
    .s1(s1), .s0(s0), .sr(sr), .sl(sl), .pdin(pdin), .pdout(pdout),
    .done(done), .err(err), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural universal shift register sharing the controller reset.
  logic [3:0] ureg;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ureg <= 4'b0000;
    else begin
      case ({s1, s0})
        2'b01:   ureg <= {sr, ureg[3:1]};
        2'b10:   ureg <= {ureg[2:0], sl};
        2'b11:   ureg <= pdin;
        default: ureg <= ureg;
      endcase
    end
  end
  assign pdout = ureg;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] cnt;
    logic [3:0] data;
    logic       sin;
    logic [3:0] rsp;
    logic       err;
    int         lat;
  } vec_t;

  typedef struct {
    logic [3:0] rsp;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];

  // Scoreboard: every done pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!done) chk("err_without_done", {31'b0, err}, 32'd0);
      else if (sb.size() == 0) chk("unexpected_done", {31'b0, done}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", {28'b0, rsp_data}, {28'b0, e.rsp});
        chk("err", {31'b0, err}, {31'b0, e.err});
        chk("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'b0, cmd_ready}, 32'd1);
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] cnt,
                       input logic [3:0] data, input logic sin);
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cmd_sin   = sin;
    cmd_valid = 1'b1;
  endtask

  task automatic run_cmd(input vec_t v);
    logic [1:0] em;
    logic [1:0] es;
    wait_ready();
    drive(v.op, v.cnt, v.data, v.sin);
    sb.push_back('{v.rsp, v.err, cyc, v.lat});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= v.lat; k++) begin
      @(negedge clk);
      em = 2'b00;
      es = 2'b00;
      if (k < v.lat) begin
        case (v.op)
          2'b00: em = 2'b11;
          2'b10: begin em = 2'b10; es = {1'b0, v.sin}; end
          2'b01: begin em = 2'b01; es = {v.sin, 1'b0}; end
          default: begin em = 2'b01; es = {pdout[0], 1'b0}; end
        endcase
      end
      chk("mode", {30'b0, s1, s0}, {30'b0, em});
      chk("serial", {30'b0, sr, sl}, {30'b0, es});
      chk("pdin", {28'b0, pdin}, (v.op == 2'b00 && k < v.lat) ? {28'b0, v.data} : 32'd0);
    end
  endtask

  vec_t vecs[13];
  bit   rot_on;
  int   c;

  initial begin
`ifdef USR_SEQ_CTRL_ROT_EN
    rot_on = 1'b1;
`else
    rot_on = 1'b0;
`endif
    //            op     cnt   data     sin   rsp      err   lat
    vecs[0]  = '{2'b00, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b0, 2};
    vecs[1]  = '{2'b00, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2};
    vecs[2]  = '{2'b01, 3'd3, 4'b0000, 1'b1, 4'b1110, 1'b0, 4};
    vecs[3]  = '{2'b00, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b0, 2};
    vecs[4]  = '{2'b10, 3'd2, 4'b0000, 1'b0, 4'b1100, 1'b0, 3};
    vecs[5]  = '{2'b00, 3'd0, 4'b0001, 1'b0, 4'b0001, 1'b0, 2};
    vecs[6]  = rot_on ? '{2'b11, 3'd1, 4'b0000, 1'b0, 4'b1000, 1'b0, 2}
                      : '{2'b11, 3'd1, 4'b0000, 1'b0, 4'b0001, 1'b1, 1};
    vecs[7]  = '{2'b01, 3'd0, 4'b0000, 1'b1, rot_on ? 4'b1000 : 4'b0001, 1'b0, 1};
    vecs[8]  = '{2'b00, 3'd0, 4'b0110, 1'b1, 4'b0110, 1'b0, 2};
    vecs[9]  = '{2'b10, 3'd7, 4'b0000, 1'b1, 4'b1111, 1'b0, 8};
    vecs[10] = '{2'b01, 3'd5, 4'b1111, 1'b0, 4'b0000, 1'b0, 6};
    vecs[11] = '{2'b00, 3'd0, 4'b1001, 1'b0, 4'b1001, 1'b0, 2};
    vecs[12] = rot_on ? '{2'b11, 3'd3, 4'b0000, 1'b1, 4'b0011, 1'b0, 4}
                      : '{2'b11, 3'd3, 4'b0000, 1'b1, 4'b1001, 1'b1, 1};

    rst_n = 1'b0;
    drive(2'b00, 3'd0, 4'b0000, 1'b0);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mode", {30'b0, s1, s0}, 32'd0);
    chk("rst_serial", {30'b0, sr, sl}, 32'd0);
    chk("rst_pdin", {28'b0, pdin}, 32'd0);
    chk("rst_done_err", {30'b0, done, err}, 32'd0);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_cmd(vecs[i]);

    // cmd_valid held high through a busy SHL; the new fields must wait for IDLE.
    run_cmd('{2'b00, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b0, 2});
    wait_ready();
    drive(2'b10, 3'd2, 4'b0000, 1'b0);
    c = cyc;
    sb.push_back('{4'b1100, 1'b0, c, 3});
    sb.push_back('{4'b0101, 1'b0, c + 4, 2});
    @(posedge clk);
    #1 drive(2'b00, 3'd0, 4'b0101, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("busy_ready", {31'b0, cmd_ready}, 32'd0);
    end
    @(negedge clk);
    chk("after_done_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    // Reset in the middle of a long shift aborts with no done pulse.
    wait_ready();
    drive(2'b01, 3'd7, 4'b0000, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_mode_before", {30'b0, s1, s0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mode", {30'b0, s1, s0}, 32'd0);
    chk("abort_serial", {30'b0, sr, sl}, 32'd0);
    chk("abort_pdin", {28'b0, pdin}, 32'd0);
    chk("abort_done_err", {30'b0, done, err}, 32'd0);
    chk("abort_ready", {31'b0, cmd_ready}, 32'd1);
    chk("abort_reg", {28'b0, pdout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_abort_ready", {31'b0, cmd_ready}, 32'd1);
      chk("post_abort_done", {31'b0, done}, 32'd0);
    end

    run_cmd('{2'b10, 3'd1, 4'b0000, 1'b1, 4'b0001, 1'b0, 2});

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usr_seq_ctrl.md
USR_SEQ_CTRL -- requirements
Module: usr_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, data width of the controlled universal shift register.
REQ-002 Parameter: CW, 3, width of the shift-count field.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset; the same net also resets the controlled register.
REQ-005 Port: cmd_valid  input  1  command offered.
REQ-006 Port: cmd_ready  output  1  controller accepts a command this cycle.
REQ-007 Port: cmd_op  input  2  operation code: 00 LOAD, 01 SHR (shift right), 10 SHL (shift left), 11 ROT (rotate right).
REQ-008 Port: cmd_cnt  input  CW  number of shift steps; ignored for LOAD.
REQ-009 Port: cmd_data  input  WIDTH  parallel value for LOAD.
REQ-010 Port: cmd_sin  input  1  serial fill bit for SHR and SHL.
REQ-011 Port: s1, s0  output  1 each  mode select to the register: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-012 Port: sr, sl  output  1 each  serial inputs to the register; SHR fills bit WIDTH-1, SHL fills bit 0.
REQ-013 Port: pdin  output  WIDTH  parallel data to the register.
REQ-014 Port: pdout  input  WIDTH  current register contents.
REQ-015 Port: done  output  1  one-cycle completion pulse.
REQ-016 Port: err  output  1  valid with done; set when the command was rejected.
REQ-017 Port: rsp_data  output  WIDTH  equals pdout while done=1.

Function
REQ-018 The controller SHALL implement the states IDLE, LOAD, SHIFT and DONE.
REQ-019 cmd_ready SHALL be 1 only in IDLE.
REQ-020 A command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1; op, cnt, data and sin SHALL be captured into registers at that edge.
REQ-021 Transitions from IDLE on accept:
- LOAD op: go to LOAD.
- Shift op with cnt>0: go to SHIFT.
- cnt=0 or a rejected op: go to DONE.
REQ-022 LOAD SHALL last exactly one cycle, with {s1,s0}=11 and pdin=captured data, then go to DONE.
REQ-023 SHIFT SHALL last exactly cnt cycles, with {s1,s0}=01 for SHR/ROT and 10 for SHL.
REQ-024 In SHIFT, sr or sl SHALL be the captured sin; for ROT, sr SHALL be pdout[0] in each cycle.
REQ-025 The shift counter SHALL decrement once per SHIFT cycle; on reaching the last step the state SHALL go to DONE.
REQ-026 DONE SHALL last one cycle with done=1 and {s1,s0}=00, then return to IDLE.
REQ-027 Latency from the accept edge: done is asserted in cycle +2 for LOAD, cycle +cnt+1 for shifts, and cycle +1 for cnt=0 or a reject.
REQ-028 Outside LOAD and SHIFT, {s1,s0} SHALL be 00 (register holds), pdin SHALL be 0, and sr and sl SHALL be 0.
REQ-029 cmd_valid asserted while busy SHALL be ignored, with no state change; back-to-back commands are accepted no sooner than the cycle after DONE.
REQ-030 err SHALL be 0 whenever done=0.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, {s1,s0}=00, sr=sl=0, pdin=0, done=0, err=0, and counter and captured fields cleared; cmd_ready=1 while in reset.
REQ-032 A reset during LOAD or SHIFT SHALL abort the command with no done pulse; the register is cleared by the shared rst_n.

Configuration
REQ-033 Macro USR_SEQ_CTRL_ROT_EN:
- Defined: ROT is executed per REQ-023 and REQ-024.
- Undefined: op 11 is rejected and goes straight to DONE with err=1; the register is never written.

Verification
REQ-034 Reset, then LOAD data=1011 -> {s1,s0}=11 for one cycle; done=1 at accept+2; rsp_data=1011; err=0.
REQ-035 From 0000, SHR cnt=3 sin=1 -> three cycles with mode 01; done at accept+4; rsp_data=1110.
REQ-036 From 1011, SHL cnt=2 sin=0 -> rsp_data=1100; cmd_valid held high throughout is accepted again only after DONE.
REQ-037 From 0001, ROT cnt=1:
- With the macro: rsp_data=1000, err=0.
- Without the macro: done at accept+1, err=1, rsp_data=0001.
REQ-038 SHR cnt=0 -> mode stays 00; done at accept+1; rsp_data is unchanged.
REQ-039 SHR cnt=7, with rst_n pulsed low at shift step 3 -> outputs return to reset values immediately; no done pulse; cmd_ready=1 after release.
